// File: rtl/stage_sequencer_pkg.sv
// stage_sequencer_pkg: stage encodings and default parameters shared by the sequencer and debug readout
package stage_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RESET_WAIT = 3'd0,
        ST_FETCH      = 3'd1,
        ST_DECODE     = 3'd2,
        ST_EXEC       = 3'd3,
        ST_MEM        = 3'd4,
        ST_WB         = 3'd5,
        ST_HALTED     = 3'd6
    } stage_e;

    localparam int unsigned DEF_RESET_DELAY = 4;
    localparam int unsigned DEF_STALL_LIMIT = 1024;
    localparam int unsigned DEF_CNT_W       = 32;

    // Width of a counter that must hold values 0..max_val (at least one bit)
    function automatic int unsigned cnt_bits(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/stage_sequencer_retire_counter.sv
// retire_counter: wrapping count of instructions retired on each enabled cycle
module retire_counter
    import stage_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             sysclk,
    input  logic             cpu_resetn,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: natural wrap from all-ones back to zero
    always_comb begin
        count_d = en ? count_q + CNT_W'(1) : count_q;
    end

    // Count register
    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: single-clock multicycle stage controller with wait stretching, halt/step and stall timeout
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int unsigned RESET_DELAY = DEF_RESET_DELAY,
    parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             sysclk,
    input  logic             cpu_resetn,
    input  logic             fetch_wait,
    input  logic             mem_wait,
    input  logic             halt_req,
    input  logic             step_mode,
    input  logic             resume,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic [2:0]       stage,
    output logic             halted,
    output logic             stall_err,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int unsigned DW = cnt_bits(RESET_DELAY);
    localparam int unsigned SW = cnt_bits(STALL_LIMIT);
    localparam logic [DW-1:0] DELAY_INIT = DW'(RESET_DELAY);
    // Counter value seen in the last permitted wait cycle; only used when the check is enabled
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);
    localparam logic CHECK_EN = (STALL_LIMIT != 0);

    stage_e         state_q, state_d;
    logic [DW-1:0]  delay_q, delay_d;
    logic [SW-1:0]  stall_q, stall_d;
    logic           stall_err_q, stall_err_d;
    logic           waiting;
    logic           stall_trip;

    // Next-state, reset-delay countdown and stall watchdog
    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        stall_err_d = stall_err_q;
        waiting     = (state_q == ST_FETCH && fetch_wait) || (state_q == ST_MEM && mem_wait);
        stall_trip  = CHECK_EN && waiting && (stall_q == STALL_LAST);
        stall_d     = (waiting && !stall_trip) ? stall_q + SW'(1) : '0;
        case (state_q)
            ST_RESET_WAIT: begin
                if (delay_q == '0) state_d = ST_FETCH;
                else delay_d = delay_q - DW'(1);
            end
            ST_FETCH:  state_d = fetch_wait ? ST_FETCH : ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_MEM;
            ST_MEM:    state_d = mem_wait ? ST_MEM : ST_WB;
            ST_WB:     state_d = (halt_req || step_mode) ? ST_HALTED : ST_FETCH;
            ST_HALTED: state_d = (resume && !halt_req) ? ST_FETCH : ST_HALTED;
            default:   state_d = ST_RESET_WAIT;
        endcase
        if (stall_trip) begin
            state_d     = ST_HALTED;
            stall_err_d = 1'b1;
        end
    end

    // State, counters and sticky error; async reset aborts any in-flight instruction
    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_q     <= ST_RESET_WAIT;
            delay_q     <= DELAY_INIT;
            stall_q     <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            stall_q     <= stall_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign fetch_en  = (state_q == ST_FETCH);
    assign decode_en = (state_q == ST_DECODE);
    assign exec_en   = (state_q == ST_EXEC);
    assign mem_en    = (state_q == ST_MEM);
    assign wb_en     = (state_q == ST_WB);
    assign halted    = (state_q == ST_HALTED);
    assign stage     = state_q;
    assign stall_err = stall_err_q;

    retire_counter #(.CNT_W(CNT_W)) u_retire (
        .sysclk     (sysclk),
        .cpu_resetn (cpu_resetn),
        .en         (wb_en),
        .count      (retire_cnt)
    );

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Central multicycle controller for the five-stage CPU (fetch, decode, execute, datamem, writeback). It replaces the free-running stage-clock ring with a single-clock FSM. The FSM produces one-hot stage enables that all run on sysclk. It also stretches the fetch and memory stages on wait requests, halts or single-steps on request, detects stuck stalls, and counts retired instructions. It sits at CPU top level; every stage register and the regfile write port qualify on its enables.

Parameters:
RESET_DELAY, 4, idle cycles after reset release before the first fetch (0 = fetch on the first edge).
STALL_LIMIT, 1024, maximum consecutive wait cycles in FETCH or MEM before a stall error (0 = check disabled).
CNT_W, 32, width of the retired-instruction counter.

Ports:
sysclk  input  1  system clock; all state changes on its rising edge
cpu_resetn  input  1  asynchronous active-low reset
fetch_wait  input  1  instruction memory not ready; hold FETCH
mem_wait  input  1  data memory or UART busy; hold MEM
halt_req  input  1  request halt at the next instruction boundary
step_mode  input  1  halt after every retired instruction
resume  input  1  leave HALTED (level-sensitive)
fetch_en  output  1  high in every FETCH cycle
decode_en  output  1  high in the DECODE cycle
exec_en  output  1  high in the EXEC cycle
mem_en  output  1  high in every MEM cycle
wb_en  output  1  high in the WB cycle; regfile write qualifier
stage  output  3  current state encoding
halted  output  1  high while in HALTED
stall_err  output  1  sticky stall-timeout flag
retire_cnt  output  CNT_W  retired-instruction count

Behaviour:
- Reset (cpu_resetn low, asynchronous):
  - state = RESET_WAIT, delay counter = RESET_DELAY, stall counter = 0.
  - retire_cnt = 0, stall_err = 0, all enables 0, halted = 0.
  - Reset asserted mid-instruction aborts it immediately; no retire is counted.
- State encoding: RESET_WAIT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6. Code 7 is illegal and goes to RESET_WAIT on the next edge.
- Outputs are Moore, decoded from the state register:
  - Exactly one enable is high in FETCH through WB; none in RESET_WAIT or HALTED.
  - stage equals the state code.
- RESET_WAIT: if delay counter == 0, go to FETCH; otherwise decrement. The first fetch_en cycle starts after RESET_DELAY+1 edges following release.
- FETCH: stay while fetch_wait = 1; otherwise go to DECODE. fetch_en stays high throughout, so the fetch register must be idempotent on repeated capture.
- DECODE, then EXEC, then MEM: unconditional, one cycle each.
- MEM: stay while mem_wait = 1; otherwise go to WB. mem_en stays high throughout. The UART store-busy condition drives mem_wait.
- WB (one cycle):
  - retire_cnt increments at the exiting edge and wraps from 2^CNT_W-1 to 0.
  - Next state is HALTED if halt_req = 1 or step_mode = 1; otherwise FETCH.
- HALTED: halted = 1.
  - If resume = 1 and halt_req = 0, go to FETCH.
  - halt_req has priority over resume. step_mode does not block resume.
- Stall counter:
  - Increments on each cycle in FETCH with fetch_wait = 1, or in MEM with mem_wait = 1.
  - Clears on any other cycle.
  - If STALL_LIMIT ≠ 0 and the counter reaches STALL_LIMIT while the wait is still high, stall_err is set and the next state is HALTED. The stalled instruction is not retired.
  - stall_err clears only on reset. Resume after a stall error restarts at FETCH.
- No-stall throughput: one instruction per 5 cycles, same as the previous ring.
- halt_req sampled outside WB has no effect until the next WB.

Decomposition:
- Shared constants package: the stage/state encodings (also used for debug readout) and the default parameter values.
- The retired-instruction counter and its wrap logic form one natural sub-module: retire_counter (enable = wb_en, width CNT_W).
- The FSM and the stall counter stay in stage_sequencer.

Test Plan:
- Reset release, RESET_DELAY=4, no waits → fetch_en first high after the 5th edge. Enables then cycle F,D,E,M,W with period 5. retire_cnt = 3 after 3 WBs.
- mem_wait high for 3 MEM cycles → mem_en high for 4 consecutive cycles, wb_en follows on the 5th, instruction takes 8 cycles, retire_cnt +1.
- step_mode=1 → one instruction then HALTED (stage=6, halted=1). resume pulse of 1 cycle → FETCH on the next edge, halted again after 5 cycles.
- STALL_LIMIT=8, fetch_wait held high → stall_err=1 and HALTED after the 8th wait cycle, retire_cnt unchanged. stall_err stays 1 across resume until cpu_resetn low.
- cpu_resetn pulsed low during EXEC → all enables 0 immediately, retire_cnt=0, restart with the RESET_DELAY sequence. Also check halt_req=1 with resume=1 in HALTED → stays HALTED.
- CNT_W=4, 16 retires from 0 → retire_cnt wraps to 0 with no glitch on stage.
